// File: rtl/writeback_rf_stage.sv
// rtl/writeback_rf_stage.sv - LC3 writeback stage: register file, result select, N/Z/P codes
// Optional WB_RF_BYPASS_EN forwards the pending commit value onto VSR1/VSR2.
module writeback_rf_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_writeback,
  input  logic [1:0]            W_Control,
  input  logic [DATA_WIDTH-1:0] aluout,
  input  logic [DATA_WIDTH-1:0] memout,
  input  logic [DATA_WIDTH-1:0] pcout,
  input  logic [AW-1:0]         dr,
  input  logic [AW-1:0]         sr1,
  input  logic [AW-1:0]         sr2,
  output logic [2:0]            psr,
  output logic [DATA_WIDTH-1:0] VSR1,
  output logic [DATA_WIDTH-1:0] VSR2,
  output logic                  enable_writeback_status
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [2:0]            psr_q, psr_d;
  logic                  status_q, status_d;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  commit;

  always_comb begin
    wb_data = '0;
    case (W_Control)
      2'd0:    wb_data = aluout;
      2'd1:    wb_data = memout;
      2'd2:    wb_data = pcout;
      default: wb_data = '0;
    endcase
  end

  assign commit = enable_writeback && (W_Control != 2'd3);

  // Non-committing cycles copy state straight through so unused X inputs never land in flops.
  always_comb begin
    regs_d   = regs_q;
    psr_d    = psr_q;
    status_d = commit;
    if (commit) begin
      regs_d[dr] = wb_data;
      if (wb_data[DATA_WIDTH-1])
        psr_d = 3'b100;
      else if (wb_data == '0)
        psr_d = 3'b010;
      else
        psr_d = 3'b001;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      psr_q    <= 3'b000;
      status_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      psr_q    <= psr_d;
      status_q <= status_d;
    end
  end

`ifdef WB_RF_BYPASS_EN
  always_comb begin
    VSR1 = (commit && (sr1 == dr)) ? wb_data : regs_q[sr1];
    VSR2 = (commit && (sr2 == dr)) ? wb_data : regs_q[sr2];
  end
`else
  always_comb begin
    VSR1 = regs_q[sr1];
    VSR2 = regs_q[sr2];
  end
`endif

  assign psr                     = psr_q;
  assign enable_writeback_status = status_q;

endmodule

// File: tb/tb_writeback_rf_stage.sv
// tb/tb_writeback_rf_stage.sv - directed self-checking bench for writeback_rf_stage
module tb_writeback_rf_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_writeback;
  logic [1:0]  W_Control;
  logic [15:0] aluout, memout, pcout;
  logic [2:0]  dr, sr1, sr2;
  logic [2:0]  psr;
  logic [15:0] VSR1, VSR2;
  logic        enable_writeback_status;

  int checks = 0;
  int errors = 0;

  writeback_rf_stage dut (
    .clock                   (clock),
    .reset                   (reset),
    .enable_writeback        (enable_writeback),
    .W_Control               (W_Control),
    .aluout                  (aluout),
    .memout                  (memout),
    .pcout                   (pcout),
    .dr                      (dr),
    .sr1                     (sr1),
    .sr2                     (sr2),
    .psr                     (psr),
    .VSR1                    (VSR1),
    .VSR2                    (VSR2),
    .enable_writeback_status (enable_writeback_status)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (reset && enable_writeback === 1'b1 && W_Control === 2'd3)
      $warning("reserved W_Control with enable_writeback set");

  task automatic drive(input logic en, input logic [1:0] wc, input logic [15:0] a,
                       input logic [15:0] m, input logic [15:0] p, input logic [2:0] d);
    enable_writeback = en;
    W_Control        = wc;
    aluout           = a;
    memout           = m;
    pcout            = p;
    dr               = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sr1 = 3'd0;
    sr2 = 3'd0;
    drive(1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (psr !== 3'b000) begin
      errors++;
      $display("FAIL reset_psr: got %b expected 000", psr);
    end
    checks++;
    if (enable_writeback_status !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got %b expected 0", enable_writeback_status);
    end
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i);
      sr2 = 3'(7 - i);
      #1;
      checks++;
      if (VSR1 !== 16'h0000 || VSR2 !== 16'h0000) begin
        errors++;
        $display("FAIL reset_regs[%0d]: got VSR1=%h VSR2=%h expected 0000", i, VSR1, VSR2);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h1234, 16'h0, 16'h0, 3'd3);
    sr1 = 3'd3;
    step();
    checks++;
    if (VSR1 !== 16'h1234 || psr !== 3'b001) begin
      errors++;
      $display("FAIL async_pre: got VSR1=%h psr=%b expected 1234 001", VSR1, psr);
    end
    drive(1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (VSR1 !== 16'h0000 || psr !== 3'b000 || enable_writeback_status !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got VSR1=%h psr=%b status=%b expected 0000 000 0",
               VSR1, psr, enable_writeback_status);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_commit_cc();
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h8001, 16'h0, 16'h0, 3'd3);
    sr1 = 3'd3;
    step();
    checks++;
    if (VSR1 !== 16'h8001 || psr !== 3'b100 || enable_writeback_status !== 1'b1) begin
      errors++;
      $display("FAIL alu_neg: got VSR1=%h psr=%b status=%b expected 8001 100 1",
               VSR1, psr, enable_writeback_status);
    end
    @(negedge clock);
    drive(1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    step();
    checks++;
    if (enable_writeback_status !== 1'b0) begin
      errors++;
      $display("FAIL status_pulse: got %b expected 0", enable_writeback_status);
    end
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h0042, 16'h0, 16'h0, 3'd5);
    step();
    @(negedge clock);
    drive(1'b1, 2'd1, 16'hxxxx, 16'h0000, 16'hxxxx, 3'd5);
    sr2 = 3'd5;
    step();
    checks++;
    if (VSR2 !== 16'h0000 || psr !== 3'b010) begin
      errors++;
      $display("FAIL mem_zero: got VSR2=%h psr=%b expected 0000 010", VSR2, psr);
    end
    @(negedge clock);
    drive(1'b1, 2'd2, 16'h0, 16'hFFFF, 16'h3005, 3'd7);
    sr2 = 3'd7;
    step();
    checks++;
    if (VSR2 !== 16'h3005 || psr !== 3'b001) begin
      errors++;
      $display("FAIL pc_pos: got VSR2=%h psr=%b expected 3005 001", VSR2, psr);
    end
  endtask

  task automatic test_hold();
    @(negedge clock);
    drive(1'b0, 2'd0, 16'hFFFF, 16'h0, 16'h0, 3'd3);
    sr1 = 3'd3;
    step();
    checks++;
    if (VSR1 !== 16'h8001 || psr !== 3'b001 || enable_writeback_status !== 1'b0) begin
      errors++;
      $display("FAIL hold_en0: got VSR1=%h psr=%b status=%b expected 8001 001 0",
               VSR1, psr, enable_writeback_status);
    end
    @(negedge clock);
    drive(1'b0, 2'bxx, 16'hxxxx, 16'hxxxx, 16'hxxxx, 3'bxxx);
    step();
    checks++;
    if (VSR1 !== 16'h8001 || psr !== 3'b001 || enable_writeback_status !== 1'b0) begin
      errors++;
      $display("FAIL hold_x: got VSR1=%h psr=%b status=%b expected 8001 001 0",
               VSR1, psr, enable_writeback_status);
    end
  endtask

  task automatic test_reserved();
    @(negedge clock);
    drive(1'b1, 2'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd3);
    sr1 = 3'd3;
    step();
    checks++;
    if (VSR1 !== 16'h8001 || psr !== 3'b001 || enable_writeback_status !== 1'b0) begin
      errors++;
      $display("FAIL reserved_wc: got VSR1=%h psr=%b status=%b expected 8001 001 0",
               VSR1, psr, enable_writeback_status);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h1111, 16'h0, 16'h0, 3'd1);
    sr1 = 3'd1;
    sr2 = 3'd2;
    step();
    checks++;
    if (enable_writeback_status !== 1'b1 || VSR1 !== 16'h1111) begin
      errors++;
      $display("FAIL b2b_first: got status=%b VSR1=%h expected 1 1111",
               enable_writeback_status, VSR1);
    end
    @(negedge clock);
    drive(1'b1, 2'd1, 16'h0, 16'hA222, 16'h0, 3'd2);
    step();
    checks++;
    if (enable_writeback_status !== 1'b1 || VSR1 !== 16'h1111 || VSR2 !== 16'hA222 || psr !== 3'b100) begin
      errors++;
      $display("FAIL b2b_second: got status=%b VSR1=%h VSR2=%h psr=%b expected 1 1111 a222 100",
               enable_writeback_status, VSR1, VSR2, psr);
    end
    @(negedge clock);
    drive(1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    step();
    checks++;
    if (enable_writeback_status !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got status=%b expected 0", enable_writeback_status);
    end
  endtask

  task automatic test_same_cycle();
    logic [15:0] exp_during;
`ifdef WB_RF_BYPASS_EN
    exp_during = 16'h0055;
`else
    exp_during = 16'h00AA;
`endif
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h00AA, 16'h0, 16'h0, 3'd4);
    step();
    @(negedge clock);
    drive(1'b1, 2'd0, 16'h0055, 16'h0, 16'h0, 3'd4);
    sr1 = 3'd4;
    sr2 = 3'd4;
    #1;
    checks++;
    if (VSR1 !== exp_during || VSR2 !== exp_during) begin
      errors++;
      $display("FAIL same_cycle_read: got VSR1=%h VSR2=%h expected %h", VSR1, VSR2, exp_during);
    end
    step();
    checks++;
    if (VSR1 !== 16'h0055 || VSR2 !== 16'h0055 || psr !== 3'b001) begin
      errors++;
      $display("FAIL same_cycle_after: got VSR1=%h VSR2=%h psr=%b expected 0055 0055 001",
               VSR1, VSR2, psr);
    end
    @(negedge clock);
    drive(1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0);
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_commit_cc();
    test_hold();
    test_reserved();
    test_back_to_back();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/writeback_rf_stage.md
Name: writeback_rf_stage

Overview:
LC3 writeback stage. It holds the 8-entry general-purpose register file and selects the result to commit from the ALU, memory or PC path. It updates the N/Z/P condition codes (psr) and supplies source-operand read values VSR1/VSR2 back to decode/execute. Its outputs psr, VSR1, VSR2 and enable_writeback_status drive the writeback_out bus, which the writeback_out monitor observes.

Parameters:
DATA_WIDTH, 16, register/result width
NUM_REGS, 8, register file depth; address width is clog2(NUM_REGS) = 3

Ports:
clock  input  1  stage clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
enable_writeback  input  1  commit strobe from controller
W_Control  input  2  result select: 0=aluout, 1=memout, 2=pcout, 3=reserved (no write)
aluout  input  16  execute ALU result
memout  input  16  memory read data
pcout  input  16  execute PC-relative result
dr  input  3  destination register index
sr1  input  3  source register 1 index
sr2  input  3  source register 2 index
psr  output  3  condition codes {N,Z,P}, registered
VSR1  output  16  RegFile[sr1]
VSR2  output  16  RegFile[sr2]
enable_writeback_status  output  1  one-cycle pulse; the previous cycle committed a write

Behaviour:
- Reset, asserted low and asynchronous:
  - all 8 registers clear to 16'h0000.
  - psr clears to 3'b000.
  - enable_writeback_status clears to 0.
  - Takes effect immediately, mid-operation included. The first commit after deassertion needs a rising edge with reset high.
- Commit condition: enable_writeback==1 AND W_Control!=3, sampled at the rising clock edge.
- On commit:
  - wb_data = mux(W_Control), sourced combinationally from the current inputs.
  - RegFile[dr] <= wb_data.
  - psr <= 3'b100 if wb_data[15]==1; 3'b010 if wb_data==0; else 3'b001. Exactly one bit is set after any commit.
  - enable_writeback_status <= 1.
- No commit (enable_writeback==0, or W_Control==3): RegFile and psr hold; enable_writeback_status <= 0.
- Latency:
  - The register write and psr update are visible one cycle after the commit edge.
  - enable_writeback_status is high for exactly one cycle per committing edge.
  - Back-to-back commits hold enable_writeback_status high continuously.
- VSR1/VSR2 are combinational reads of RegFile indexed by sr1/sr2; they reflect the post-edge contents.
- sr1==sr2 is legal; both outputs show the same value.
- Same-cycle read of register dr while committing returns the OLD value (base build, no bypass).
- W_Control==3 with enable_writeback==1 is a no-op. A bench assertion flags it as a warning, not an error.
- No unknowns: wb_data is fully defined for W_Control 0..2. X on unused inputs must not reach state when no commit occurs.
- No stalls or handshake back-pressure. The controller guarantees inputs are stable around the edge.

Optional Feature:
Macro WB_RF_BYPASS_EN.
- Defined: write-through bypass. When a commit is pending this cycle and sr1==dr (or sr2==dr), VSR1 (or VSR2) returns wb_data combinationally instead of the stored value. psr and register-write timing are unchanged.
- Undefined: no bypass; same-cycle reads return the pre-write contents, as above.

Test Plan:
- Reset checks (no commit in between):
  - Hold reset low 3 cycles, then release → psr==3'b000, VSR1==VSR2==16'h0000 for every sr1/sr2, enable_writeback_status==0.
  - Commit R3=16'h1234, then drop reset low mid-cycle (asynchronous) → R3 reads 0 and psr==0 before the next edge.
- Commit and condition-code checks:
  - enable_writeback=1, W_Control=0, aluout=16'h8001, dr=3 → next cycle VSR1(sr1=3)==16'h8001, psr==3'b100, enable_writeback_status pulses once.
  - W_Control=1, memout=16'h0000, dr=5 → psr==3'b010, R5==0.
  - W_Control=2, pcout=16'h3005, dr=7 → psr==3'b001, R7==16'h3005.
- Hold checks:
  - enable_writeback=0, aluout=16'hFFFF, dr=3 → R3 and psr unchanged, enable_writeback_status==0.
  - W_Control=3, enable_writeback=1 → no write, psr held, status==0.
- Back-to-back commits to R1, then R2, with sr1=1, sr2=2 → status high 2 consecutive cycles, both values read correctly.
- Same-cycle read/write, R4 preloaded with 16'h00AA, then commit 16'h0055 to dr=4 with sr1=4:
  - during the commit cycle VSR1==16'h00AA (base build), or 16'h0055 (WB_RF_BYPASS_EN).
  - after the edge VSR1==16'h0055 in both builds.
